// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32I core pipeline.
//   XLEN        - architectural register width
//   wb_state_e  - writeback stage FSM states
//   F3_*        - load funct3 encodings
package cpu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        WAIT_LD = 2'd1,
        COMMIT  = 2'd2
    } wb_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Load data alignment and extension (purely combinational).
//   funct3_i  - load type (LB/LH/LW/LBU/LHU; undefined codes act as LW)
//   addr_lo_i - byte offset of the load address
//   rdata_i   - raw data-memory word
//   result_o  - aligned, sign/zero-extended register value
module load_extend
    import cpu_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // NOTE: every signal assigned here gets a value on every path (default
        // first); a missed branch would infer a latch.
        byte_sel = rdata_i[7:0];
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase

        // Halfwords are assumed aligned: only addr_lo[1] picks the half.
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        result_o = rdata_i;
        case (funct3_i)
            F3_LB:   result_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  result_o = {24'd0, byte_sel};
            F3_LH:   result_o = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  result_o = {16'd0, half_sel};
            F3_LW:   result_o = rdata_i;
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage of the RV32I pipeline.
//   clk, rst                  - clock, asynchronous active-low reset
//   mem_valid / mem_ready     - handshake with the MEM stage
//   mem_rd, mem_we, mem_is_load, mem_funct3, mem_addr_lo, mem_result
//                             - retiring instruction fields
//   dm_rvalid, dm_rdata       - data-memory read return (one-cycle pulse)
//   wb_en, wb_data, rd_index  - register-file write port (one cycle per retire)
//   ld_pending, ld_pending_rd - outstanding load, for the hazard unit
//   spurious_rvalid           - sticky: read data arrived with no load waiting
//   instret                   - 64-bit retired-instruction counter
module wb_stage
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [4:0]      mem_rd,
    input  logic            mem_we,
    input  logic            mem_is_load,
    input  logic [2:0]      mem_funct3,
    input  logic [1:0]      mem_addr_lo,
    input  logic [XLEN-1:0] mem_result,
    input  logic            dm_rvalid,
    input  logic [XLEN-1:0] dm_rdata,
    output logic            wb_en,
    output logic [XLEN-1:0] wb_data,
    output logic [4:0]      rd_index,
    output logic            ld_pending,
    output logic [4:0]      ld_pending_rd,
    output logic            spurious_rvalid,
    output logic [63:0]     instret
);

    wb_state_e       state_q, state_d;
    logic [4:0]      rd_q, rd_d;
    logic            we_q, we_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [1:0]      addr_lo_q, addr_lo_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [63:0]     instret_q, instret_d;
    logic            spurious_q, spurious_d;

    logic            accept;
    logic [XLEN-1:0] load_word;

    // Extension uses the latched load attributes and the live memory word.
    load_extend u_load_extend (
        .funct3_i  (funct3_q),
        .addr_lo_i (addr_lo_q),
        .rdata_i   (dm_rdata),
        .result_o  (load_word)
    );

    assign accept = mem_valid && (state_q != WAIT_LD);

    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        we_d       = we_q;
        funct3_d   = funct3_q;
        addr_lo_d  = addr_lo_q;
        data_d     = data_q;
        instret_d  = instret_q + {63'd0, (state_q == COMMIT)};
        spurious_d = spurious_q | (dm_rvalid && (state_q != WAIT_LD));

        case (state_q)
            EMPTY, COMMIT: begin
                if (accept) begin
                    rd_d      = mem_rd;
                    we_d      = mem_we;
                    funct3_d  = mem_funct3;
                    addr_lo_d = mem_addr_lo;
                    if (mem_is_load) begin
                        state_d = WAIT_LD;
                    end else begin
                        data_d  = mem_result;
                        state_d = COMMIT;
                    end
                end else if (state_q == COMMIT) begin
                    // Clear the write-port registers so EMPTY presents zeros.
                    state_d   = EMPTY;
                    rd_d      = '0;
                    we_d      = 1'b0;
                    funct3_d  = '0;
                    addr_lo_d = '0;
                    data_d    = '0;
                end
            end
            WAIT_LD: begin
                if (dm_rvalid) begin
                    data_d  = load_word;
                    state_d = COMMIT;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= EMPTY;
            rd_q       <= '0;
            we_q       <= 1'b0;
            funct3_q   <= '0;
            addr_lo_q  <= '0;
            data_q     <= '0;
            instret_q  <= '0;
            spurious_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q    <= state_d;
            rd_q       <= rd_d;
            we_q       <= we_d;
            funct3_q   <= funct3_d;
            addr_lo_q  <= addr_lo_d;
            data_q     <= data_d;
            instret_q  <= instret_d;
            spurious_q <= spurious_d;
        end
    end

    assign mem_ready       = (state_q != WAIT_LD);
    assign wb_en           = (state_q == COMMIT) && we_q && (rd_q != 5'd0);
    assign wb_data         = data_q;
    assign rd_index        = rd_q;
    assign ld_pending      = (state_q == WAIT_LD);
    assign ld_pending_rd   = rd_q;
    assign spurious_rvalid = spurious_q;
    assign instret         = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios followed by randomized
// instruction streams compared against a transaction-level reference model.
module tb_wb_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic        mem_we;
    logic        mem_is_load;
    logic [2:0]  mem_funct3;
    logic [1:0]  mem_addr_lo;
    logic [31:0] mem_result;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        wb_en;
    logic [31:0] wb_data;
    logic [4:0]  rd_index;
    logic        ld_pending;
    logic [4:0]  ld_pending_rd;
    logic        spurious_rvalid;
    logic [63:0] instret;

    int              checks = 0;
    int              errors = 0;
    longint unsigned retired = 0;
    logic            exp_spur = 1'b0;

    wb_stage dut (
        .clk             (clk),
        .rst             (rst),
        .mem_valid       (mem_valid),
        .mem_ready       (mem_ready),
        .mem_rd          (mem_rd),
        .mem_we          (mem_we),
        .mem_is_load     (mem_is_load),
        .mem_funct3      (mem_funct3),
        .mem_addr_lo     (mem_addr_lo),
        .mem_result      (mem_result),
        .dm_rvalid       (dm_rvalid),
        .dm_rdata        (dm_rdata),
        .wb_en           (wb_en),
        .wb_data         (wb_data),
        .rd_index        (rd_index),
        .ld_pending      (ld_pending),
        .ld_pending_rd   (ld_pending_rd),
        .spurious_rvalid (spurious_rvalid),
        .instret         (instret)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference load result from the ISA rules using shifts and masks.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lo,
                                               input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * lo)) & 32'hFF;
        h = (w >> (16 * lo[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'd128)   ? b - 32'd256   : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    task automatic check_idle(input string tag);
        check({tag, ".wb_en"},      {63'd0, wb_en}, 64'd0);
        check({tag, ".wb_data"},    {32'd0, wb_data}, 64'd0);
        check({tag, ".rd_index"},   {59'd0, rd_index}, 64'd0);
        check({tag, ".ld_pending"}, {63'd0, ld_pending}, 64'd0);
        check({tag, ".pend_rd"},    {59'd0, ld_pending_rd}, 64'd0);
        check({tag, ".mem_ready"},  {63'd0, mem_ready}, 64'd1);
        check({tag, ".instret"},    instret, retired);
        check({tag, ".spurious"},   {63'd0, spurious_rvalid}, {63'd0, exp_spur});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            check_idle("idle");
        end
    endtask

    // Presents one instruction, returns at the falling edge of its COMMIT cycle
    // so a following call retires back-to-back.
    task automatic issue(input logic [4:0] rd, input logic we, input logic ld,
                         input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] res,
                         input int lat, input logic [31:0] word, input logic same_rv);
        logic [31:0] exp;
        mem_valid   = 1'b1;
        mem_rd      = rd;
        mem_we      = we;
        mem_is_load = ld;
        mem_funct3  = f3;
        mem_addr_lo = lo;
        mem_result  = res;
        if (same_rv) begin
            dm_rvalid = 1'b1;
            dm_rdata  = $urandom;
        end
        #1 check("ready_at_accept", {63'd0, mem_ready}, 64'd1);
        @(posedge clk);
        #1;
        mem_valid   = 1'b0;
        mem_result  = $urandom;
        dm_rvalid   = 1'b0;
        if (same_rv) exp_spur = 1'b1;
        if (ld) begin
            exp = model_load(f3, lo, word);
            for (int i = 1; i <= lat; i++) begin
                @(negedge clk);
                check("wait.ld_pending", {63'd0, ld_pending}, 64'd1);
                check("wait.mem_ready",  {63'd0, mem_ready}, 64'd0);
                check("wait.pend_rd",    {59'd0, ld_pending_rd}, {59'd0, rd});
                check("wait.wb_en",      {63'd0, wb_en}, 64'd0);
                check("wait.spurious",   {63'd0, spurious_rvalid}, {63'd0, exp_spur});
                if (i == lat) begin
                    dm_rvalid = 1'b1;
                    dm_rdata  = word;
                end
                @(posedge clk);
                #1;
                dm_rvalid = 1'b0;
                dm_rdata  = $urandom;
            end
        end else begin
            exp = res;
        end
        @(negedge clk);
        check("commit.wb_en",      {63'd0, wb_en}, {63'd0, (we && rd != 5'd0)});
        check("commit.wb_data",    {32'd0, wb_data}, {32'd0, exp});
        check("commit.rd_index",   {59'd0, rd_index}, {59'd0, rd});
        check("commit.ld_pending", {63'd0, ld_pending}, 64'd0);
        check("commit.instret",    instret, retired);
        check("commit.spurious",   {63'd0, spurious_rvalid}, {63'd0, exp_spur});
        retired++;
    endtask

    initial begin
        rst         = 1'b0;
        mem_valid   = 1'b0;
        mem_rd      = '0;
        mem_we      = 1'b0;
        mem_is_load = 1'b0;
        mem_funct3  = '0;
        mem_addr_lo = '0;
        mem_result  = '0;
        dm_rvalid   = 1'b0;
        dm_rdata    = '0;

        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        #1 check_idle("reset");
        @(negedge clk);
        rst = 1'b1;
        #1 check_idle("post_reset");

        // Back-to-back non-loads.
        issue(5'd5, 1'b1, 1'b0, 3'd0, 2'd0, 32'hDEADBEEF, 0, 32'd0, 1'b0);
        issue(5'd6, 1'b1, 1'b0, 3'd0, 2'd0, 32'h00000001, 0, 32'd0, 1'b0);
        idle(1);
        check("b2b.instret", instret, 64'd2);

        // LB from byte 3, then LHU from the upper half of the same word.
        issue(5'd7, 1'b1, 1'b1, F3_LB,  2'd3, 32'd0, 4, 32'h80FF_0000, 1'b0);
        check("lb.value", {32'd0, wb_data}, 64'hFFFFFF80);
        issue(5'd8, 1'b1, 1'b1, F3_LHU, 2'd2, 32'd0, 2, 32'h80FF_0000, 1'b0);
        check("lhu.value", {32'd0, wb_data}, 64'h000080FF);
        idle(1);

        // Write to x0 retires without a register-file write.
        issue(5'd0, 1'b1, 1'b0, 3'd0, 2'd0, 32'h12345678, 0, 32'd0, 1'b0);
        idle(1);
        check("x0.instret", instret, 64'd5);

        // Read data with nothing waiting sets the sticky flag.
        dm_rvalid = 1'b1;
        @(posedge clk);
        #1 dm_rvalid = 1'b0;
        exp_spur = 1'b1;
        idle(3);

        // Randomized instruction stream.
        for (int n = 0; n < 200; n++) begin
            logic [4:0]  r_rd;
            logic        r_ld;
            r_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            r_ld = 1'($urandom);
            issue(r_rd, 1'($urandom), r_ld, 3'($urandom), 2'($urandom), $urandom,
                  int'($urandom_range(1, 4)), $urandom,
                  r_ld && ($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
        end
        idle(1);

        // Reset while a load is waiting drops it.
        mem_valid   = 1'b1;
        mem_rd      = 5'd9;
        mem_we      = 1'b1;
        mem_is_load = 1'b1;
        mem_funct3  = F3_LW;
        @(posedge clk);
        #1 mem_valid = 1'b0;
        @(negedge clk);
        check("rstld.pending_before", {63'd0, ld_pending}, 64'd1);
        rst      = 1'b0;
        retired  = 0;
        exp_spur = 1'b0;
        #1 check_idle("rstld.in_reset");
        @(negedge clk);
        rst = 1'b1;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
